// File: rtl/freq_divider_prog_if.sv
// Control/status bundle for the programmable divider: divisor programming in,
// divided clock, period tick and update status out.
interface freq_divider_prog_if #(
  parameter int NUM_DIVISOR_BITS = 8
);
  logic                        enable;
  logic                        load;
  logic [NUM_DIVISOR_BITS-1:0] divisor;
  logic                        out;
  logic                        tick;
  logic                        pending;
  logic [NUM_DIVISOR_BITS-1:0] div_active;

  modport master (
    output enable, load, divisor,
    input  out, tick, pending, div_active
  );

  modport slave (
    input  enable, load, divisor,
    output out, tick, pending, div_active
  );
endinterface

// File: rtl/freq_divider_prog.sv
// Programmable integer clock divider (2..2^W-1, odd or even) with a shadow
// divisor that is only adopted at a period boundary so the output never glitches.
module freq_divider_prog #(
  parameter int NUM_DIVISOR_BITS = 8
) (
  input  logic                 in,
  input  logic                 reset,
  freq_divider_prog_if.slave   bus
);
  localparam int W = NUM_DIVISOR_BITS;

  logic [W-1:0] d_reg, d_next;
  logic [W-1:0] s_reg, s_next;
  logic [W-1:0] cnt_reg, cnt_next;
  logic         out_reg, out_next;
  logic         tick_reg, tick_next;
  logic         pending_reg, pending_next;

  logic         running;
  logic         at_end;
  logic         boundary;
  logic [W-1:0] cnt_wrap;
  logic [W:0]   half;
  logic         s_running;

  // Period bookkeeping; half is widened so D=2^W-1 cannot overflow.
  always_comb begin
    running   = (d_reg >= W'(2));
    at_end    = (cnt_reg == (d_reg - W'(1)));
    boundary  = !running || at_end;
    cnt_wrap  = at_end ? '0 : (cnt_reg + W'(1));
    half      = ({1'b0, d_reg} + (W+1)'(1)) >> 1;
    s_running = (s_reg >= W'(2));
  end

  always_comb begin
    d_next       = d_reg;
    s_next       = s_reg;
    cnt_next     = cnt_reg;
    out_next     = out_reg;
    tick_next    = 1'b0;
    pending_next = pending_reg;

    if (bus.enable) begin
      if (boundary && pending_reg) begin
        d_next       = s_reg;
        cnt_next     = '0;
        out_next     = s_running;
        tick_next    = s_running;
        pending_next = 1'b0;
      end else if (!running) begin
        cnt_next = '0;
        out_next = 1'b0;
      end else begin
        cnt_next  = cnt_wrap;
        out_next  = ({1'b0, cnt_wrap} < half);
        tick_next = (cnt_wrap == '0);
      end
    end

    // A load on a boundary edge lands after the old shadow value was consumed.
    if (bus.load) begin
      s_next       = bus.divisor;
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge in) begin
    if (reset) begin
      d_reg       <= '0;
      s_reg       <= '0;
      cnt_reg     <= '0;
      out_reg     <= 1'b0;
      tick_reg    <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      d_reg       <= d_next;
      s_reg       <= s_next;
      cnt_reg     <= cnt_next;
      out_reg     <= out_next;
      tick_reg    <= tick_next;
      pending_reg <= pending_next;
    end
  end

  assign bus.out        = out_reg;
  assign bus.tick       = tick_reg;
  assign bus.pending    = pending_reg;
  assign bus.div_active = d_reg;
endmodule

// File: tb/tb_freq_divider_prog.sv
// Bench for freq_divider_prog: a period-queue reference model checked every
// cycle, plus hand-computed waveform snippets for the directed scenarios.
module tb_freq_divider_prog;
  localparam int W = 8;

  logic in;
  logic reset;
  freq_divider_prog_if #(.NUM_DIVISOR_BITS(W)) bus ();

  freq_divider_prog #(.NUM_DIVISOR_BITS(W)) dut (
    .in    (in),
    .reset (reset),
    .bus   (bus)
  );

  initial in = 1'b0;
  always #5 in = ~in;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  // Reference model: at each boundary the whole coming period is laid out as a
  // queue of {out,tick} pairs; each enabled edge consumes one entry.
  int       m_d, m_s;
  bit       m_pend, m_out, m_tick;
  logic [1:0] m_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input bit l, input int dv);
    int high_cnt;
    logic [1:0] ent;
    if (r) begin
      m_d = 0; m_s = 0; m_pend = 0; m_out = 0; m_tick = 0;
      m_q.delete();
      return;
    end
    if (e) begin
      if (m_q.size() == 0) begin
        if (m_pend) begin
          m_d    = m_s;
          m_pend = 0;
        end
        if (m_d >= 2) begin
          high_cnt = (m_d % 2 == 0) ? m_d / 2 : (m_d + 1) / 2;
          for (int i = 0; i < m_d; i++)
            m_q.push_back({(i < high_cnt) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0});
        end
      end
      if (m_q.size() != 0) begin
        ent    = m_q.pop_front();
        m_out  = ent[1];
        m_tick = ent[0];
      end else begin
        m_out  = 0;
        m_tick = 0;
      end
    end else begin
      m_tick = 0;
    end
    if (l) begin
      m_s    = dv;
      m_pend = 1;
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    while (!done) begin
      @(posedge in);
      model_edge(reset, bus.enable, bus.load, int'(bus.divisor));
      #1;
      chk("out",        32'(bus.out),        32'(m_out));
      chk("tick",       32'(bus.tick),       32'(m_tick));
      chk("pending",    32'(bus.pending),    32'(m_pend));
      chk("div_active", 32'(bus.div_active), 32'(m_d));
    end
  end

  task automatic step(input logic r, input logic e, input logic l, input logic [W-1:0] dv);
    @(negedge in);
    reset       = r;
    bus.enable  = e;
    bus.load    = l;
    bus.divisor = dv;
    @(posedge in);
    #2;
  endtask

  logic [15:0] rec_out, rec_tick;

  initial begin
    reset       = 1'b1;
    bus.enable  = 1'b0;
    bus.load    = 1'b0;
    bus.divisor = '0;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 1, 1, 8'd9);
    chk("rst_out", 32'(bus.out), 0);
    chk("rst_pending", 32'(bus.pending), 0);
    chk("rst_div", 32'(bus.div_active), 0);

    // Divide by 4 from idle
    step(0, 1, 1, 8'd4);
    chk("d4_pending_set", 32'(bus.pending), 1);
    chk("d4_div_before", 32'(bus.div_active), 0);
    step(0, 1, 0, 0);
    chk("d4_first_out", 32'(bus.out), 1);
    chk("d4_first_tick", 32'(bus.tick), 1);
    chk("d4_div", 32'(bus.div_active), 4);
    chk("d4_pending_clr", 32'(bus.pending), 0);
    rec_out = '0; rec_tick = '0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0);
      rec_out  = {rec_out[14:0], bus.out};
      rec_tick = {rec_tick[14:0], bus.tick};
    end
    chk("d4_out_seq", 32'(rec_out[7:0]), 32'h99);
    chk("d4_tick_seq", 32'(rec_tick[7:0]), 32'h11);

    // Divide by 5 from idle
    step(1, 0, 0, 0);
    step(0, 1, 1, 8'd5);
    step(0, 1, 0, 0);
    chk("d5_first_out", 32'(bus.out), 1);
    chk("d5_first_tick", 32'(bus.tick), 1);
    rec_out = '0; rec_tick = '0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0);
      rec_out  = {rec_out[14:0], bus.out};
      rec_tick = {rec_tick[14:0], bus.tick};
    end
    chk("d5_out_seq", 32'(rec_out[9:0]), 32'(10'b1100111001));
    chk("d5_tick_seq", 32'(rec_tick[9:0]), 32'(10'b0000100001));

    // Running 6, switch to 3 mid-period
    step(1, 0, 0, 0);
    step(0, 1, 1, 8'd6);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    rec_out = '0;
    step(0, 1, 1, 8'd3);
    rec_out = {rec_out[14:0], bus.out};
    chk("d6to3_pending", 32'(bus.pending), 1);
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 0, 0);
      rec_out = {rec_out[14:0], bus.out};
    end
    chk("d6to3_out_seq", 32'(rec_out[9:0]), 32'(10'b0001101101));
    chk("d6to3_div", 32'(bus.div_active), 3);

    // Last load wins within one period
    step(1, 0, 0, 0);
    step(0, 1, 1, 8'd4);
    step(0, 1, 0, 0);
    step(0, 1, 1, 8'd7);
    step(0, 1, 1, 8'd9);
    chk("lw_div_old", 32'(bus.div_active), 4);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("lw_div_new", 32'(bus.div_active), 9);
    chk("lw_out", 32'(bus.out), 1);

    // Enable low freezes the period; load during freeze waits
    step(1, 0, 0, 0);
    step(0, 1, 1, 8'd4);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, (i == 2), 8'd2);
    chk("frz_out", 32'(bus.out), 1);
    chk("frz_tick", 32'(bus.tick), 0);
    chk("frz_div", 32'(bus.div_active), 4);
    chk("frz_pending", 32'(bus.pending), 1);
    rec_out = '0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0);
      rec_out = {rec_out[14:0], bus.out};
    end
    chk("frz_resume_seq", 32'(rec_out[4:0]), 32'(5'b00101));

    // Load 1 -> idle, load 2 -> toggle, then reset with an update pending
    step(0, 1, 1, 8'd1);
    step(0, 1, 0, 0);
    chk("idle_out", 32'(bus.out), 0);
    chk("idle_tick", 32'(bus.tick), 0);
    chk("idle_div", 32'(bus.div_active), 1);
    step(0, 1, 1, 8'd2);
    rec_out = '0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      rec_out = {rec_out[14:0], bus.out};
    end
    chk("d2_out_seq", 32'(rec_out[3:0]), 32'(4'b1010));
    step(0, 1, 1, 8'd5);
    chk("pre_rst_out", 32'(bus.out), 1);
    chk("pre_rst_pending", 32'(bus.pending), 1);
    step(1, 1, 0, 0);
    chk("mid_rst_out", 32'(bus.out), 0);
    chk("mid_rst_pending", 32'(bus.pending), 0);
    chk("mid_rst_div", 32'(bus.div_active), 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);

    done = 1'b1;
    @(posedge in);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
